mesh_boot_ctrl: RTL

Boot sequencer and end-of-computation collector for the RedMulE tile mesh. Distributes a boot address and staggered fetch-enables to `N_TILES` tiles, captures each tile's 8-bit exit code on its EOC, and reports a packed mesh exit code, a pass flag and a watchdog timeout. Sits between the mesh control interface and the tile array, replacing per-tile boot handling.

---
 rtl/mesh_boot_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mesh_boot_ctrl.sv
// Boot sequencer and end-of-computation collector for the RedMulE tile mesh.
// Define MESH_BOOT_STAGGER_EN to stagger tile fetch-enables by STAGGER_CYC cycles.
module mesh_boot_ctrl #(
    parameter int unsigned N_TILES     = 4,
    parameter int unsigned STAGGER_CYC = 4,
    parameter int unsigned TIMEOUT_W   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [31:0]            boot_addr_i,
    input  logic [TIMEOUT_W-1:0]   timeout_i,
    input  logic [N_TILES-1:0]     tile_eoc_i,
    input  logic [N_TILES*8-1:0]   tile_exit_code_i,
    output logic [N_TILES-1:0]     fetch_en_o,
    output logic [31:0]            boot_addr_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N_TILES-1:0]     eoc_mask_o,
    output logic [N_TILES*8-1:0]   exit_code_o,
    output logic                   timeout_o,
    output logic                   pass_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBoot = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    if (STAGGER_CYC < 1) begin : g_bad_stagger
        $error("STAGGER_CYC must be at least 1");
    end

    if (N_TILES < 1 || N_TILES > 64) begin : g_bad_tiles
        $error("N_TILES must be in 1..64");
    end

    logic [1:0]             state_q, state_d;
    logic [N_TILES-1:0]     fetch_en_q, fetch_en_d;
    logic [N_TILES-1:0]     eoc_mask_q, eoc_mask_d;
    logic [N_TILES-1:0]     new_cap, mask_nxt;
    logic [31:0]            boot_addr_q, boot_addr_d;
    logic [TIMEOUT_W-1:0]   limit_q, limit_d;
    logic [TIMEOUT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [N_TILES*8-1:0]   exit_code_q, exit_code_d, code_nxt;
    logic                   timed_out_q, timed_out_d;
    logic                   pass_q, pass_d;
    logic                   wd_expire;

`ifdef MESH_BOOT_STAGGER_EN
    localparam int unsigned StagW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam logic [N_TILES-1:0] FirstEn = N_TILES'(1);
    logic [StagW-1:0] stag_q, stag_d;
`else
    localparam logic [N_TILES-1:0] FirstEn = '1;
`endif

    // Only enabled tiles that have not reported yet can be captured.
    assign new_cap   = fetch_en_q & tile_eoc_i & ~eoc_mask_q;
    assign mask_nxt  = eoc_mask_q | new_cap;
    assign wd_expire = (limit_q != '0) && (wd_cnt_q == limit_q - TIMEOUT_W'(1));

    always_comb begin
        code_nxt = exit_code_q;
        for (int k = 0; k < N_TILES; k++) begin
            if (new_cap[k]) begin
                code_nxt[8*k +: 8] = tile_exit_code_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_en_d  = fetch_en_q;
        boot_addr_d = boot_addr_q;
        limit_d     = limit_q;
        wd_cnt_d    = wd_cnt_q;
        eoc_mask_d  = eoc_mask_q;
        exit_code_d = exit_code_q;
        timed_out_d = timed_out_q;
        pass_d      = pass_q;
`ifdef MESH_BOOT_STAGGER_EN
        stag_d      = stag_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d     = StBoot;
                    fetch_en_d  = FirstEn;
                    boot_addr_d = boot_addr_i;
                    limit_d     = timeout_i;
                    wd_cnt_d    = '0;
                    eoc_mask_d  = '0;
                    exit_code_d = '0;
                    timed_out_d = 1'b0;
                    pass_d      = 1'b0;
`ifdef MESH_BOOT_STAGGER_EN
                    stag_d      = '0;
`endif
                end
            end
            StBoot, StRun: begin
                eoc_mask_d  = mask_nxt;
                exit_code_d = code_nxt;
                if (limit_q != '0) begin
                    wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
                end
                if (state_q == StBoot) begin
                    if (fetch_en_q[N_TILES-1]) begin
                        state_d = StRun;
                    end
`ifdef MESH_BOOT_STAGGER_EN
                    // Enables form a thermometer code, so the next tile is one shift away.
                    else if (stag_q == StagW'(STAGGER_CYC - 1)) begin
                        fetch_en_d = fetch_en_q | (fetch_en_q << 1);
                        stag_d     = '0;
                    end else begin
                        stag_d = stag_q + StagW'(1);
                    end
`endif
                end
                // A completing EOC takes precedence over a simultaneous watchdog expiry.
                if (state_q == StRun && (&mask_nxt)) begin
                    state_d    = StDone;
                    fetch_en_d = '0;
                    pass_d     = (code_nxt == '0);
                end else if (wd_expire && !(&mask_nxt)) begin
                    state_d     = StDone;
                    fetch_en_d  = '0;
                    timed_out_d = 1'b1;
                    pass_d      = 1'b0;
                    for (int k = 0; k < N_TILES; k++) begin
                        if (!mask_nxt[k]) begin
                            exit_code_d[8*k +: 8] = 8'hFF;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            fetch_en_q  <= '0;
            boot_addr_q <= '0;
            limit_q     <= '0;
            wd_cnt_q    <= '0;
            eoc_mask_q  <= '0;
            exit_code_q <= '0;
            timed_out_q <= 1'b0;
            pass_q      <= 1'b0;
`ifdef MESH_BOOT_STAGGER_EN
            stag_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_en_q  <= fetch_en_d;
            boot_addr_q <= boot_addr_d;
            limit_q     <= limit_d;
            wd_cnt_q    <= wd_cnt_d;
            eoc_mask_q  <= eoc_mask_d;
            exit_code_q <= exit_code_d;
            timed_out_q <= timed_out_d;
            pass_q      <= pass_d;
`ifdef MESH_BOOT_STAGGER_EN
            stag_q      <= stag_d;
`endif
        end
    end

    assign fetch_en_o  = fetch_en_q;
    assign boot_addr_o = boot_addr_q;
    assign busy_o      = (state_q == StBoot) || (state_q == StRun);
    assign done_o      = (state_q == StDone);
    assign eoc_mask_o  = eoc_mask_q;
    assign exit_code_o = exit_code_q;
    assign timeout_o   = timed_out_q;
    assign pass_o      = pass_q;

endmodule
